// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction fetch port (IF)
//   and the load/store port (D). One requester is granted at a time. The
//   memory request is registered and held until the memory acknowledges it.
//   Data accesses win ties. A starvation counter forces a fetch grant after
//   STARVE_LIMIT consecutive data grants made while a fetch was waiting.
//
// Ports
//   i_clk, i_reset         clock (rising edge), async active-high reset
//   i_if_req/i_if_addr     fetch request level and byte address
//   i_if_flush             drop the result of the fetch in flight
//   o_if_rdata/o_if_ready  fetched word and one-cycle completion pulse
//   o_if_stall             i_if_req & ~o_if_ready, freezes PC and IF/ID
//   i_d_req/i_d_we         data request level, 1 = store
//   i_d_addr/i_d_wdata     data byte address and store data
//   i_d_wstrb              store byte enables
//   o_d_rdata/o_d_ready    load data and one-cycle completion pulse
//   o_mem_*                registered request to the memory
//   i_mem_rdata/i_mem_ack  memory read data and completion
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ready,
  output logic        o_if_stall,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_wstrb,
  output logic [31:0] o_d_rdata,
  output logic        o_d_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_next;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [3:0]  r_starve;
  logic        r_discard;

  logic        w_grant_d;
  logic        w_grant_if;
  logic        w_ack;
  logic        w_starved;
  logic        w_if_ready;
  logic        w_d_ready;

  // The ack only means something while a request is outstanding.
  assign w_ack     = r_mem_req & i_mem_ack;
  // A waiting fetch that has lost STARVE_LIMIT times in a row takes the tie.
  assign w_starved = i_if_req & (r_starve == LIMIT);

  // Next-state and grant decode
  always_comb begin
    w_next     = r_state;
    w_grant_d  = 1'b0;
    w_grant_if = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_d_req && !w_starved) begin
          w_grant_d = 1'b1;
          w_next    = D_BUSY;
        end else if (i_if_req) begin
          w_grant_if = 1'b1;
          w_next     = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (w_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Memory request registers: loaded on a grant, frozen until the ack.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else if (w_grant_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= i_d_we;
      r_mem_addr  <= {i_d_addr[31:2], 2'b00};
      r_mem_wdata <= i_d_wdata;
      r_mem_wstrb <= i_d_we ? i_d_wstrb : 4'b0000;
    end else if (w_grant_if) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {i_if_addr[31:2], 2'b00};
      r_mem_wstrb <= 4'b0000;
    end else if (w_ack) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (w_grant_if) begin
      r_starve <= '0;
    end else if (w_grant_d) begin
      if (!i_if_req)             r_starve <= '0;
      else if (r_starve != LIMIT) r_starve <= r_starve + 4'd1;
    end
  end

  // Discard flag: a flush during a fetch lets the memory finish but hides
  // the result. A flush in the ack cycle itself is handled combinationally.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_discard <= 1'b0;
    end else if (r_state == IF_BUSY) begin
      if (w_ack)           r_discard <= 1'b0;
      else if (i_if_flush) r_discard <= 1'b1;
    end
  end

  assign w_d_ready  = (r_state == D_BUSY) & i_mem_ack;
  assign w_if_ready = (r_state == IF_BUSY) & i_mem_ack & ~r_discard & ~i_if_flush;

  assign o_d_ready   = w_d_ready;
  assign o_if_ready  = w_if_ready;
  assign o_d_rdata   = w_d_ready  ? i_mem_rdata : 32'h0;
  assign o_if_rdata  = w_if_ready ? i_mem_rdata : 32'h0;
  assign o_if_stall  = i_if_req & ~w_if_ready;

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready, if_stall;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_err = 0;
  int mem_wait = 0;
  int wcnt;
  logic [31:0] memarr [0:255];

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_rdata(if_rdata), .o_if_ready(if_ready), .o_if_stall(if_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_wstrb(d_wstrb), .o_d_rdata(d_rdata), .o_d_ready(d_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 65) return 32'h0000_0013;
    if (i == 4)  return 32'h1234_5678;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Memory model: ack after mem_wait wait states, drops everything on reset.
  assign mem_ack   = mem_req && (wcnt == mem_wait);
  assign mem_rdata = memarr[mem_addr[9:2]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) memarr[i] <= init_val(i);
    end else begin
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (mem_req && mem_ack && mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) memarr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [136:0] obs;
    #1 reset = 1'b1;
    #3;
    obs = {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ready, d_ready,
           if_rdata, d_rdata, if_stall};
    n_cmp++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_state got=%h exp=0", obs);
    end
    cyc(); cyc(); reset = 1'b0;
  endtask

  task automatic test_fetch();
    int stalls = 0, k = 0;
    mem_wait = 0;
    cyc(); if_req = 1'b1; if_addr = 32'h0000_0104;
    smp();
    while (!if_ready && k < 20) begin
      if (if_stall) stalls++;
      cyc(); smp(); k++;
    end
    n_cmp++;
    if ({if_ready, if_rdata, mem_addr, mem_wstrb, if_stall} !== {1'b1, 32'h13, 32'h104, 4'b0, 1'b0}) begin
      n_err++; $display("FAIL fetch_done got rdy=%b data=%h addr=%h strb=%b stall=%b exp 1/13/104/0/0",
                        if_ready, if_rdata, mem_addr, mem_wstrb, if_stall);
    end
    n_cmp++;
    if (stalls != 1) begin n_err++; $display("FAIL fetch_stall_cycles got=%0d exp=1", stalls); end
    cyc(); if_req = 1'b0;
    smp();
    n_cmp++;
    if ({if_ready, if_rdata, mem_req} !== 34'h0) begin
      n_err++; $display("FAIL fetch_after got rdy=%b data=%h req=%b exp 0", if_ready, if_rdata, mem_req);
    end
  endtask

  task automatic test_simultaneous();
    int k = 1;
    mem_wait = 2;
    cyc();
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2003; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b1000;
    cyc(); smp();
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 32'h2000, 32'hDEADBEEF, 4'b1000}) begin
      n_err++; $display("FAIL simul_dgrant got req=%b we=%b addr=%h wd=%h strb=%b exp 1/1/2000/deadbeef/1000",
                        mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    while (!d_ready && k < 10) begin cyc(); smp(); k++; end
    n_cmp++;
    if (k != 3) begin n_err++; $display("FAIL simul_dready_lat got=%0d exp=3", k); end
    cyc(); d_req = 1'b0;
    smp();
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL simul_idle got=%b exp=0", mem_req); end
    cyc(); smp();
    n_cmp++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h300}) begin
      n_err++; $display("FAIL simul_ifgrant got req=%b we=%b addr=%h exp 1/0/300", mem_req, mem_we, mem_addr);
    end
    k = 0;
    while (!if_ready && k < 10) begin cyc(); smp(); k++; end
    n_cmp++;
    if (if_rdata !== init_val(192)) begin
      n_err++; $display("FAIL simul_ifdata got=%h exp=%h", if_rdata, init_val(192));
    end
    cyc(); if_req = 1'b0;
  endtask

  task automatic test_starvation();
    int got[$];
    int exp_cnt = 0, k = 0;
    logic prev = 1'b0;
    pulse_reset();
    mem_wait = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    while (got.size() < 10 && k < 60) begin
      smp();
      if (mem_req && !prev) got.push_back((mem_addr == 32'h400) ? 2 : 1);
      prev = mem_req;
      cyc(); k++;
    end
    d_req = 1'b0; if_req = 1'b0;
    n_cmp++;
    if (got.size() != 10) begin n_err++; $display("FAIL starve_count got=%0d exp=10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      int e;
      if (exp_cnt == LIMIT) begin e = 1; exp_cnt = 0; end
      else begin e = 2; exp_cnt++; end
      n_cmp++;
      if (got[i] != e) begin n_err++; $display("FAIL starve_grant%0d got=%0d exp=%0d (1=IF 2=D)", i, got[i], e); end
    end
    cyc(); cyc();
  endtask

  task automatic test_flush();
    int nreq = 0, k = 0;
    logic saw = 1'b0, moved = 1'b0, ack = 1'b0;
    mem_wait = 3;
    cyc(); if_req = 1'b1; if_addr = 32'h0000_0180;
    cyc(); if_flush = 1'b1;
    do begin
      smp();
      if (mem_req) nreq++;
      if (if_ready) saw = 1'b1;
      if (mem_addr !== 32'h180) moved = 1'b1;
      ack = mem_ack;
      cyc(); if_flush = 1'b0;
    end while (!ack && nreq < 12);
    if_addr = 32'h0000_0200;
    n_cmp++;
    if ({nreq, saw, moved} !== {32'd4, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL flush_hold got cycles=%0d ready_seen=%b addr_moved=%b exp 4/0/0", nreq, saw, moved);
    end
    mem_wait = 0;
    cyc(); smp();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL flush_regrant got req=%b addr=%h exp 1/200", mem_req, mem_addr);
    end
    while (!if_ready && k < 10) begin cyc(); smp(); k++; end
    n_cmp++;
    if ({if_ready, if_rdata} !== {1'b1, init_val(128)}) begin
      n_err++; $display("FAIL flush_newdata got rdy=%b data=%h exp 1/%h", if_ready, if_rdata, init_val(128));
    end
    cyc(); if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_wait = 5;
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0024;
    cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, d_ready, d_rdata, mem_addr} !== '0) begin
      n_err++; $display("FAIL resetmid got req=%b rdy=%b data=%h addr=%h exp 0", mem_req, d_ready, d_rdata, mem_addr);
    end
    d_req = 1'b0;
    cyc(); cyc(); reset = 1'b0; mem_wait = 0;
    smp();
    n_cmp++;
    if ({mem_req, d_ready} !== 2'b00) begin
      n_err++; $display("FAIL resetmid_idle got req=%b rdy=%b exp 0", mem_req, d_ready);
    end
    cyc(); d_req = 1'b1; d_addr = 32'h0000_0010;
    cyc(); smp();
    n_cmp++;
    if ({mem_req, mem_addr, d_ready, d_rdata} !== {1'b1, 32'h10, 1'b1, 32'h12345678}) begin
      n_err++; $display("FAIL resetmid_cold got req=%b addr=%h rdy=%b data=%h exp 1/10/1/12345678",
                        mem_req, mem_addr, d_ready, d_rdata);
    end
    cyc(); d_req = 1'b0;
  endtask

  task automatic test_load();
    mem_wait = 1;
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010; d_wstrb = 4'hF;
    for (int k = 0; k < 6; k++) begin
      smp();
      n_cmp++;
      if ({d_ready, d_rdata} !== {(k == 2), ((k == 2) ? 32'h12345678 : 32'h0)} ||
          (mem_req && mem_we !== 1'b0)) begin
        n_err++; $display("FAIL load_c%0d got rdy=%b data=%h we=%b exp %b/%h/0", k, d_ready, d_rdata, mem_we,
                          (k == 2), ((k == 2) ? 32'h12345678 : 32'h0));
      end
      cyc();
      if (k == 2) d_req = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [31:0] refm [0:255];
    logic [31:0] ia, da, dwd;
    logic        dw;
    logic [3:0]  ds;
    logic        prev_mreq = 1'b0, prev_d = 1'b0, prev_i = 1'b0;
    logic        d_done = 1'b0, i_done = 1'b0, edr, eir;
    int          cur = 0, cnt = 0, win;
    logic [31:0] exp_addr;
    pulse_reset();
    for (int i = 0; i < 256; i++) refm[i] = init_val(i);
    ia = 0; da = 0; dwd = 0; dw = 0; ds = 0;
    mem_wait = 0;
    for (int c = 0; c < 1500; c++) begin
      smp();
      if (!prev_mreq) begin
        // Arbitration rule at an idle edge, in terms of the request levels seen there.
        win = (prev_d && (!prev_i || cnt != LIMIT)) ? 2 : (prev_i ? 1 : 0);
        n_cmp++;
        if (mem_req !== (win != 0)) begin
          n_err++; $display("FAIL rnd_grant c=%0d got req=%b exp=%b", c, mem_req, win != 0);
        end
        if (win == 2) begin
          n_cmp++;
          if ({mem_we, mem_addr, mem_wstrb} !== {dw, da[31:2], 2'b00, (dw ? ds : 4'b0)} ||
              (dw && mem_wdata !== dwd)) begin
            n_err++; $display("FAIL rnd_dgrant c=%0d got we=%b addr=%h strb=%b wd=%h exp %b/%h/%b/%h",
                              c, mem_we, mem_addr, mem_wstrb, mem_wdata, dw, {da[31:2], 2'b00}, ds, dwd);
          end
          cnt = prev_i ? ((cnt < LIMIT) ? cnt + 1 : LIMIT) : 0;
        end else if (win == 1) begin
          n_cmp++;
          if ({mem_we, mem_addr, mem_wstrb} !== {1'b0, ia[31:2], 2'b00, 4'b0}) begin
            n_err++; $display("FAIL rnd_igrant c=%0d got we=%b addr=%h strb=%b exp 0/%h/0",
                              c, mem_we, mem_addr, mem_wstrb, {ia[31:2], 2'b00});
          end
          cnt = 0;
        end
        cur = win;
      end else if (mem_req) begin
        exp_addr = (cur == 2) ? {da[31:2], 2'b00} : {ia[31:2], 2'b00};
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_err++; $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, mem_addr, exp_addr);
        end
      end
      edr = (cur == 2) && mem_req && mem_ack;
      eir = (cur == 1) && mem_req && mem_ack;
      n_cmp++;
      if ({d_ready, if_ready, d_rdata, if_rdata, if_stall} !==
          {edr, eir, (edr ? refm[da[9:2]] : 32'h0), (eir ? refm[ia[9:2]] : 32'h0), (if_req & ~eir)}) begin
        n_err++; $display("FAIL rnd_ready c=%0d got dr=%b ir=%b dd=%h id=%h st=%b exp %b/%b/%h/%h",
                          c, d_ready, if_ready, d_rdata, if_rdata, if_stall, edr, eir,
                          (edr ? refm[da[9:2]] : 32'h0), (eir ? refm[ia[9:2]] : 32'h0));
      end
      if (edr) begin
        if (dw) for (int b = 0; b < 4; b++) if (ds[b]) refm[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
        d_done = 1'b1;
      end
      if (eir) i_done = 1'b1;
      prev_mreq = mem_req; prev_d = d_req; prev_i = if_req;
      cyc();
      if (d_done) begin d_req = 1'b0; d_done = 1'b0; end
      if (i_done) begin if_req = 1'b0; i_done = 1'b0; end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        dw = 1'($urandom_range(0, 1)); da = 32'($urandom_range(0, 1023));
        dwd = $urandom; ds = 4'($urandom_range(0, 15));
        d_req = 1'b1; d_we = dw; d_addr = da; d_wdata = dwd; d_wstrb = ds;
      end
      if (!if_req && $urandom_range(0, 1) == 0) begin
        ia = 32'($urandom_range(0, 255)) << 2;
        if_req = 1'b1; if_addr = ia;
      end
      if (!mem_req) mem_wait = $urandom_range(0, 3);
    end
    d_req = 1'b0; if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_load();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the IF stage's instruction fetch port and the MEM stage's load/store port. It grants one requester at a time, drives a registered request/acknowledge memory transaction, and returns read data and a one-cycle ready pulse to the winner. It also generates the fetch-side stall that freezes the PC and the IF/ID register while a fetch is pending. Data accesses have priority, with a starvation guard so fetches always make progress.

## Interface

- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending; range 1..15.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, level; held until if_ready
- if_addr  in  32  fetch byte address; stable while if_req=1
- if_flush  in  1  pipeline flush; discards the in-flight fetch result
- if_rdata  out  32  fetched instruction; valid only when if_ready=1
- if_ready  out  1  one-cycle fetch completion pulse
- if_stall  out  1  combinational: if_req & ~if_ready
- d_req  in  1  data request, level; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_wstrb  in  4  byte enables for a store; ignored for a load
- d_rdata  out  32  load data; valid only when d_ready=1
- d_ready  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request; registered
- mem_we  out  1  registered write enable
- mem_addr  out  32  registered word address, bits [1:0] forced to 00
- mem_wdata  out  32  registered write data
- mem_wstrb  out  4  registered byte enables; 0000 for reads
- mem_rdata  in  32  read data; valid in the mem_ack cycle
- mem_ack  in  1  transaction done; sampled only while mem_req=1

## Operation

- States:
  - IDLE
  - IF_BUSY
  - D_BUSY
- Reset values:
  - state IDLE
  - mem_req, mem_we = 0
  - mem_addr, mem_wdata = 0
  - mem_wstrb = 0000
  - starvation counter 0
  - discard flag 0
  - if_ready, d_ready = 0
  - if_rdata, d_rdata = 0
- Arbitration in IDLE, at the clock edge:
  - d_req only -> D_BUSY.
  - if_req only -> IF_BUSY.
  - Both asserted -> D_BUSY, unless the counter equals STARVE_LIMIT, in which case -> IF_BUSY.
  - Neither -> stay in IDLE.
- On grant, the arbiter latches the winner's address, write enable, data and strobes into the mem_* registers and sets mem_req=1.
  - For a fetch grant, mem_we=0 and mem_wstrb=0000.
- Starvation counter:
  - Increments on each data grant made while if_req=1, saturating at STARVE_LIMIT.
  - Clears on every fetch grant.
  - Clears on any data grant made while if_req=0.
- In IF_BUSY or D_BUSY:
  - mem_* outputs are held constant until mem_ack=1.
  - On the ack edge: mem_req <- 0, state <- IDLE.
- Ready pulses (combinational):
  - d_ready = (state==D_BUSY) & mem_ack.
  - if_ready = (state==IF_BUSY) & mem_ack & ~discard & ~if_flush.
- Read data: d_rdata and if_rdata are mem_rdata passed through while the matching ready is high, and 0 otherwise.
- Flush:
  - if_flush=1 in IF_BUSY before the ack sets the discard flag.
  - The memory transaction still completes; it is never abandoned on flush.
  - if_ready is suppressed for that fetch, and the discard flag clears on the ack edge.
  - if_flush in IDLE or D_BUSY has no effect on the arbiter.
  - The IF stage then re-requests at the new PC.
- Requesters must not change address or data while their request is pending. A change is a protocol violation; the latched values are used.
- Asynchronous reset during a transaction: all registers return to their reset values immediately (mem_req falls without waiting for the ack). The memory model must drop an unacknowledged transaction on reset.

## Timing

- Grant edge N: mem_req=1 during cycle N+1.
- The earliest ack is in cycle N+1 (zero-wait memory). The ready pulse occurs in the same cycle as mem_ack.
- The state is IDLE at N+2, so the next grant can occur at edge N+2.
- Minimum occupancy is 2 cycles per transaction. Peak throughput is one access per 2 cycles.
- Each wait state of the memory adds exactly 1 cycle.
- A request asserted in the same cycle as another requester's ack is arbitrated at the following IDLE edge, not the ack edge.

## Test plan

- Zero-wait single fetch:
  - Stimulus: if_req=1, if_addr=0x00000104, mem_ack returned in the first mem_req cycle with mem_rdata=0x00000013.
  - Required response: mem_addr=0x00000104, mem_wstrb=0000, if_ready pulses for 1 cycle with if_rdata=0x00000013, and if_stall is high for exactly 1 cycle before that pulse.
- Simultaneous arrival in IDLE:
  - Stimulus: if_req and d_req asserted together; the data request is a store with d_addr=0x00002003, d_wdata=0xDEADBEEF, d_wstrb=1000; memory has 2 wait states.
  - Required response:
    - D_BUSY is granted first, with mem_addr=0x00002000.
    - d_ready arrives 3 cycles after the grant.
    - The fetch is granted on the next IDLE edge.
- Starvation limit with STARVE_LIMIT=4:
  - Stimulus: d_req held continuously and if_req held.
  - Required response:
    - Grant sequence is D,D,D,D,IF,D,D,D,D,IF.
    - The counter returns to 0 after each IF grant.
- Flush mid-fetch:
  - Stimulus: if_flush pulsed in cycle 1 of an IF_BUSY transaction with 3 wait states.
  - Required response:
    - mem_req is held until the ack.
    - No if_ready pulse occurs for that fetch.
    - The next if_req (new PC 0x00000200) is granted normally and returns data.
- Reset mid-transaction:
  - Stimulus: reset asserted during D_BUSY before the ack.
  - Required response:
    - mem_req, d_ready and state go to their reset values with no clock edge needed.
    - After reset release, the first grant behaves as from a cold start.
- Load data pass-through:
  - Stimulus: a load at d_addr=0x00000010 with mem_rdata=0x12345678.
  - Required response: d_rdata=0x12345678 only in the d_ready cycle; d_rdata=0 in all other cycles; mem_we=0.
